// File: rtl/alu_input_sequencer.sv
// ---------------------------------------------------------------------------
// alu_input_sequencer
//
// Front-end stage sitting directly upstream of the ALU control FSM. It
// synchronises and debounces the raw LOAD and CONFIRM push-buttons, turns
// their debounced rising edges into press pulses, captures the operand and
// opcode switches, and drives the FSM handshake inputs as single-cycle
// registered pulses. Operands and opcode are frozen from capture until the
// FSM has had time to register its result (the HOLD phase).
//
// Ports:
//   clk              system clock, rising edge
//   reset            synchronous, active-high reset
//   btn_load_raw     raw LOAD button (asynchronous), 1 = pressed
//   btn_confirm_raw  raw CONFIRM button (asynchronous), 1 = pressed
//   sw_a, sw_b       operand switches (quasi-static)
//   sw_op            opcode switches (quasi-static)
//   operand_a/_b     registered operands to the FSM
//   switch_op        registered opcode to the FSM
//   handshaking      one-cycle pulse: new operands captured from IDLE
//   confirm_op       one-cycle pulse: operation confirmed
//   busy             high whenever the sequencer is not IDLE
//   seq_state        current state encoding (debug)
// ---------------------------------------------------------------------------
module alu_input_sequencer #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
    parameter int HOLD_CYCLES     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_load_raw,
    input  logic       btn_confirm_raw,
    input  logic [1:0] sw_a,
    input  logic [1:0] sw_b,
    input  logic [1:0] sw_op,
    output logic [1:0] operand_a,
    output logic [1:0] operand_b,
    output logic [1:0] switch_op,
    output logic       handshaking,
    output logic       confirm_op,
    output logic       busy,
    output logic [1:0] seq_state
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ARMED = 2'b01;
    localparam logic [1:0] ST_HOLD  = 2'b10;

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    // The level flips on the edge where the counter would reach
    // DEBOUNCE_CYCLES, i.e. after exactly DEBOUNCE_CYCLES disagreeing cycles.
    localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);

    // -----------------------------------------------------------------------
    // One debounce step: returns {next_level, next_count}.
    // A disagreement between the synchronised input and the accepted level
    // advances the counter; any agreement (including a glitch reverting)
    // clears it, so only an unbroken run of DEBOUNCE_CYCLES flips the level.
    // -----------------------------------------------------------------------
    function automatic logic [CNT_W:0] debounce_step(
        input logic             synced,
        input logic             level,
        input logic [CNT_W-1:0] count
    );
        logic [CNT_W:0] result;
        if (synced != level) begin
            if (count == DEB_LAST) begin
                result = {synced, CNT_ZERO};
            end else begin
                result = {level, count + CNT_ONE};
            end
        end else begin
            result = {level, CNT_ZERO};
        end
        return result;
    endfunction

    // -----------------------------------------------------------------------
    // Registers and next-state signals
    // -----------------------------------------------------------------------
    logic             load_sync1_r;
    logic             load_sync2_r;
    logic             confirm_sync1_r;
    logic             confirm_sync2_r;

    logic             load_deb_r;
    logic             confirm_deb_r;
    logic [CNT_W-1:0] load_cnt_r;
    logic [CNT_W-1:0] confirm_cnt_r;
    logic             load_deb_prev_r;
    logic             confirm_deb_prev_r;

    logic [CNT_W:0]   load_deb_next_s;
    logic [CNT_W:0]   confirm_deb_next_s;

    logic             load_p_s;
    logic             confirm_p_s;

    logic [1:0]       state_r;
    logic [1:0]       state_next_s;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_next_s;
    logic             capture_s;
    logic             handshaking_next_s;
    logic             confirm_op_next_s;

    logic [1:0]       operand_a_r;
    logic [1:0]       operand_b_r;
    logic [1:0]       switch_op_r;
    logic             handshaking_r;
    logic             confirm_op_r;
    logic             busy_r;

    // Two-flop synchronisers bring the raw buttons into the clk domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_sync1_r    <= 1'b0;
            load_sync2_r    <= 1'b0;
            confirm_sync1_r <= 1'b0;
            confirm_sync2_r <= 1'b0;
        end else begin
            load_sync1_r    <= btn_load_raw;
            load_sync2_r    <= load_sync1_r;
            confirm_sync1_r <= btn_confirm_raw;
            confirm_sync2_r <= confirm_sync1_r;
        end
    end

    // Next debounced level and counter for both buttons.
    always_comb begin
        load_deb_next_s    = debounce_step(load_sync2_r, load_deb_r, load_cnt_r);
        confirm_deb_next_s = debounce_step(confirm_sync2_r, confirm_deb_r, confirm_cnt_r);
    end

    // Debounced levels, their counters and the one-cycle-old copies used
    // for rising-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_deb_r         <= 1'b0;
            load_cnt_r         <= CNT_ZERO;
            confirm_deb_r      <= 1'b0;
            confirm_cnt_r      <= CNT_ZERO;
            load_deb_prev_r    <= 1'b0;
            confirm_deb_prev_r <= 1'b0;
        end else begin
            load_deb_r         <= load_deb_next_s[CNT_W];
            load_cnt_r         <= load_deb_next_s[CNT_W-1:0];
            confirm_deb_r      <= confirm_deb_next_s[CNT_W];
            confirm_cnt_r      <= confirm_deb_next_s[CNT_W-1:0];
            load_deb_prev_r    <= load_deb_r;
            confirm_deb_prev_r <= confirm_deb_r;
        end
    end

    // Press pulses: debounced rising edges only. A held button stays at
    // level 1 and produces no further pulse until it is released.
    always_comb begin
        load_p_s    = load_deb_r & ~load_deb_prev_r;
        confirm_p_s = confirm_deb_r & ~confirm_deb_prev_r;
    end

    // Sequencer next-state logic, capture strobe and pulse requests.
    always_comb begin
        state_next_s       = state_r;
        hold_cnt_next_s    = hold_cnt_r;
        capture_s          = 1'b0;
        handshaking_next_s = 1'b0;
        confirm_op_next_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A confirm press with nothing loaded is ignored.
                if (load_p_s) begin
                    state_next_s       = ST_ARMED;
                    capture_s          = 1'b1;
                    handshaking_next_s = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                // Confirm takes priority over a simultaneous load so the
                // operands the FSM is about to use are not disturbed.
                if (confirm_p_s) begin
                    state_next_s      = ST_HOLD;
                    confirm_op_next_s = 1'b1;
                    hold_cnt_next_s   = HOLD_ZERO;
                end else if (load_p_s) begin
                    // Re-capture only; the FSM is already waiting, so no
                    // second handshake.
                    state_next_s = ST_ARMED;
                    capture_s    = 1'b1;
                end else begin
                    state_next_s = ST_ARMED;
                end
            end
            ST_HOLD: begin
                // Buttons are ignored while the FSM finishes its result.
                if (hold_cnt_r == HOLD_LAST) begin
                    state_next_s    = ST_IDLE;
                    hold_cnt_next_s = HOLD_ZERO;
                end else begin
                    state_next_s    = ST_HOLD;
                    hold_cnt_next_s = hold_cnt_r + HOLD_ONE;
                end
            end
            default: begin
                // Unreachable encoding: recover to IDLE.
                state_next_s    = ST_IDLE;
                hold_cnt_next_s = HOLD_ZERO;
            end
        endcase
    end

    // State, hold counter and the registered status/pulse outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            hold_cnt_r    <= HOLD_ZERO;
            handshaking_r <= 1'b0;
            confirm_op_r  <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            hold_cnt_r    <= hold_cnt_next_s;
            handshaking_r <= handshaking_next_s;
            confirm_op_r  <= confirm_op_next_s;
            busy_r        <= (state_next_s != ST_IDLE);
        end
    end

    // Operand and opcode registers: written only on a capture edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            operand_a_r <= 2'b00;
            operand_b_r <= 2'b00;
            switch_op_r <= 2'b00;
        end else if (capture_s) begin
            operand_a_r <= sw_a;
            operand_b_r <= sw_b;
            switch_op_r <= sw_op;
        end else begin
            operand_a_r <= operand_a_r;
            operand_b_r <= operand_b_r;
            switch_op_r <= switch_op_r;
        end
    end

    assign operand_a   = operand_a_r;
    assign operand_b   = operand_b_r;
    assign switch_op   = switch_op_r;
    assign handshaking = handshaking_r;
    assign confirm_op  = confirm_op_r;
    assign busy        = busy_r;
    assign seq_state   = state_r;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for alu_input_sequencer with
// DEBOUNCE_CYCLES=4 and HOLD_CYCLES=3. Inputs are driven and outputs are
// sampled on the falling edge. A small downstream FSM model registers an
// ALU result two cycles after each confirm_op pulse.
// ---------------------------------------------------------------------------
module tb_alu_input_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_load_raw = 1'b0;
    logic       btn_confirm_raw = 1'b0;
    logic [1:0] sw_a = 2'b00;
    logic [1:0] sw_b = 2'b00;
    logic [1:0] sw_op = 2'b00;
    logic [1:0] operand_a;
    logic [1:0] operand_b;
    logic [1:0] switch_op;
    logic       handshaking;
    logic       confirm_op;
    logic       busy;
    logic [1:0] seq_state;

    int tests = 0;
    int fails = 0;
    int hs_cnt = 0;
    int cf_cnt = 0;
    int both_cnt = 0;

    alu_input_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_load_raw(btn_load_raw),
        .btn_confirm_raw(btn_confirm_raw),
        .sw_a(sw_a),
        .sw_b(sw_b),
        .sw_op(sw_op),
        .operand_a(operand_a),
        .operand_b(operand_b),
        .switch_op(switch_op),
        .handshaking(handshaking),
        .confirm_op(confirm_op),
        .busy(busy),
        .seq_state(seq_state)
    );

    always #5 clk = ~clk;

    // Downstream FSM model: confirm_op -> WAIT -> EXECUTE registers result.
    logic       fsm_exec;
    logic [2:0] alu_result;

    function automatic logic [2:0] alu_fn(input logic [1:0] a, input logic [1:0] b,
                                          input logic [1:0] op);
        case (op)
            2'b00:   return {1'b0, a} + {1'b0, b};
            2'b01:   return {1'b0, a} - {1'b0, b};
            2'b10:   return {1'b0, a & b};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            fsm_exec   <= 1'b0;
            alu_result <= 3'b000;
        end else begin
            fsm_exec <= confirm_op;
            if (fsm_exec) alu_result <= alu_fn(operand_a, operand_b, switch_op);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance n cycles, tallying output pulses seen on each falling edge.
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (handshaking) hs_cnt++;
            if (confirm_op) cf_cnt++;
            if (handshaking && confirm_op) both_cnt++;
        end
    endtask

    task automatic clear_counts();
        hs_cnt = 0;
        cf_cnt = 0;
        both_cnt = 0;
    endtask

    task automatic do_reset();
        btn_load_raw = 1'b0;
        btn_confirm_raw = 1'b0;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    task automatic release_all();
        btn_load_raw = 1'b0;
        btn_confirm_raw = 1'b0;
        step(8);
    endtask

    // Load (10,01,11) and return with buttons released, sequencer ARMED.
    task automatic arm_default();
        sw_a = 2'b10; sw_b = 2'b01; sw_op = 2'b11;
        btn_load_raw = 1'b1;
        step(8);
        release_all();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        btn_load_raw = 1'b1;
        btn_confirm_raw = 1'b1;
        sw_a = 2'b11; sw_b = 2'b11; sw_op = 2'b11;
        step(3);
        tests++;
        if ({operand_a, operand_b, switch_op, handshaking, confirm_op, busy, seq_state} !== 11'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %b required all zero",
                     {operand_a, operand_b, switch_op, handshaking, confirm_op, busy, seq_state});
        end
        reset = 1'b0;
        clear_counts();
        run_cycles(12);
        tests++;
        if (hs_cnt !== 1) begin
            fails++;
            $display("FAIL reset_release_load: got %0d handshakes required 1", hs_cnt);
        end
        tests++;
        if (cf_cnt !== 0 || seq_state !== 2'b01) begin
            fails++;
            $display("FAIL reset_release_state: got cf=%0d state=%b required cf=0 state=01",
                     cf_cnt, seq_state);
        end
        release_all();
    endtask

    task automatic test_load_capture();
        do_reset();
        sw_a = 2'b10; sw_b = 2'b01; sw_op = 2'b11;
        btn_load_raw = 1'b1;
        clear_counts();
        run_cycles(6);
        tests++;
        if (hs_cnt !== 0) begin
            fails++;
            $display("FAIL load_early: got %0d handshakes before cycle 7 required 0", hs_cnt);
        end
        step(1);
        tests++;
        if (handshaking !== 1'b1 || seq_state !== 2'b01 || busy !== 1'b1) begin
            fails++;
            $display("FAIL load_pulse: got hs=%b state=%b busy=%b required 1 01 1",
                     handshaking, seq_state, busy);
        end
        tests++;
        if ({operand_a, operand_b, switch_op} !== 6'b10_01_11) begin
            fails++;
            $display("FAIL load_operands: got %b required 100111", {operand_a, operand_b, switch_op});
        end
        // Switches moving without a press must not disturb the captured values.
        sw_a = 2'b00; sw_b = 2'b10; sw_op = 2'b00;
        step(1);
        tests++;
        if (handshaking !== 1'b0) begin
            fails++;
            $display("FAIL load_pulse_width: got hs=%b required 0", handshaking);
        end
        clear_counts();
        run_cycles(10);
        tests++;
        if (hs_cnt !== 0 || operand_a !== 2'b10) begin
            fails++;
            $display("FAIL load_held: got hs=%0d a=%b required 0 10", hs_cnt, operand_a);
        end
        release_all();
    endtask

    // Continues from ARMED with (10,01,11) left by test_load_capture.
    task automatic test_confirm_hold();
        sw_a = 2'b01; sw_b = 2'b11; sw_op = 2'b01;
        btn_confirm_raw = 1'b1;
        clear_counts();
        run_cycles(6);
        tests++;
        if (cf_cnt !== 0) begin
            fails++;
            $display("FAIL confirm_early: got %0d confirms required 0", cf_cnt);
        end
        step(1);
        tests++;
        if (confirm_op !== 1'b1 || handshaking !== 1'b0 || seq_state !== 2'b10) begin
            fails++;
            $display("FAIL confirm_pulse: got cf=%b hs=%b state=%b required 1 0 10",
                     confirm_op, handshaking, seq_state);
        end
        step(1);
        tests++;
        if (confirm_op !== 1'b0 || seq_state !== 2'b10) begin
            fails++;
            $display("FAIL confirm_hold2: got cf=%b state=%b required 0 10", confirm_op, seq_state);
        end
        step(1);
        tests++;
        if (seq_state !== 2'b10 || alu_result !== 3'b011) begin
            fails++;
            $display("FAIL confirm_hold3: got state=%b alu=%b required 10 011", seq_state, alu_result);
        end
        step(1);
        tests++;
        if (seq_state !== 2'b00 || busy !== 1'b0) begin
            fails++;
            $display("FAIL hold_exit: got state=%b busy=%b required 00 0", seq_state, busy);
        end
        tests++;
        if ({operand_a, operand_b, switch_op} !== 6'b10_01_11) begin
            fails++;
            $display("FAIL hold_operands: got %b required 100111", {operand_a, operand_b, switch_op});
        end
        release_all();
    endtask

    task automatic test_bounce();
        do_reset();
        clear_counts();
        btn_load_raw = 1'b1; run_cycles(3);
        btn_load_raw = 1'b0; run_cycles(1);
        btn_load_raw = 1'b1; run_cycles(2);
        btn_load_raw = 1'b0; run_cycles(10);
        tests++;
        if (hs_cnt !== 0 || seq_state !== 2'b00) begin
            fails++;
            $display("FAIL bounce_reject: got hs=%0d state=%b required 0 00", hs_cnt, seq_state);
        end
        btn_confirm_raw = 1'b1;
        clear_counts();
        run_cycles(10);
        tests++;
        if (cf_cnt !== 0 || seq_state !== 2'b00) begin
            fails++;
            $display("FAIL idle_confirm: got cf=%0d state=%b required 0 00", cf_cnt, seq_state);
        end
        release_all();
    endtask

    task automatic test_recapture();
        do_reset();
        arm_default();
        sw_a = 2'b11;
        btn_load_raw = 1'b1;
        clear_counts();
        run_cycles(10);
        tests++;
        if (hs_cnt !== 0 || seq_state !== 2'b01) begin
            fails++;
            $display("FAIL recapture_ctrl: got hs=%0d state=%b required 0 01", hs_cnt, seq_state);
        end
        tests++;
        if ({operand_a, operand_b, switch_op} !== 6'b11_01_11) begin
            fails++;
            $display("FAIL recapture_ops: got %b required 110111", {operand_a, operand_b, switch_op});
        end
        release_all();
        // Load pressed one cycle after confirm lands its pulse inside HOLD.
        sw_a = 2'b00; sw_b = 2'b10; sw_op = 2'b01;
        clear_counts();
        btn_confirm_raw = 1'b1;
        run_cycles(1);
        btn_load_raw = 1'b1;
        run_cycles(14);
        tests++;
        if (hs_cnt !== 0 || cf_cnt !== 1 || seq_state !== 2'b00) begin
            fails++;
            $display("FAIL hold_load_ignored: got hs=%0d cf=%0d state=%b required 0 1 00",
                     hs_cnt, cf_cnt, seq_state);
        end
        tests++;
        if ({operand_a, operand_b, switch_op} !== 6'b11_01_11) begin
            fails++;
            $display("FAIL hold_load_ops: got %b required 110111", {operand_a, operand_b, switch_op});
        end
        release_all();
    endtask

    task automatic test_simultaneous();
        do_reset();
        arm_default();
        sw_a = 2'b01; sw_b = 2'b11; sw_op = 2'b00;
        btn_load_raw = 1'b1;
        btn_confirm_raw = 1'b1;
        clear_counts();
        run_cycles(7);
        tests++;
        if (confirm_op !== 1'b1 || hs_cnt !== 0 || seq_state !== 2'b10) begin
            fails++;
            $display("FAIL simul_confirm: got cf=%b hs=%0d state=%b required 1 0 10",
                     confirm_op, hs_cnt, seq_state);
        end
        tests++;
        if ({operand_a, operand_b, switch_op} !== 6'b10_01_11) begin
            fails++;
            $display("FAIL simul_no_capture: got %b required 100111", {operand_a, operand_b, switch_op});
        end
        run_cycles(6);
        tests++;
        if (both_cnt !== 0 || cf_cnt !== 1) begin
            fails++;
            $display("FAIL simul_pulses: got both=%0d cf=%0d required 0 1", both_cnt, cf_cnt);
        end
        release_all();
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        arm_default();
        btn_confirm_raw = 1'b1;
        step(7);
        tests++;
        if (confirm_op !== 1'b1) begin
            fails++;
            $display("FAIL rih_confirm: got cf=%b required 1", confirm_op);
        end
        step(1);
        reset = 1'b1;
        step(1);
        tests++;
        if ({operand_a, operand_b, switch_op, handshaking, confirm_op, busy, seq_state} !== 11'd0) begin
            fails++;
            $display("FAIL rih_outputs: got %b required all zero",
                     {operand_a, operand_b, switch_op, handshaking, confirm_op, busy, seq_state});
        end
        reset = 1'b0;
        clear_counts();
        run_cycles(10);
        tests++;
        if (cf_cnt !== 0 || seq_state !== 2'b00) begin
            fails++;
            $display("FAIL rih_after: got cf=%0d state=%b required 0 00", cf_cnt, seq_state);
        end
        release_all();
    endtask

    initial begin
        test_reset();
        test_load_capture();
        test_confirm_hold();
        test_bounce();
        test_recapture();
        test_simultaneous();
        test_reset_in_hold();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
